// File: rtl/dtc_inverse_search.sv
// Inverse-query engine: sweeps every candidate through an external combinational
// classifier and reports the lowest vector hitting a target class plus the hit count.
// Optional early exit on first match: define DTC_SEARCH_EARLY_EXIT_EN.
module dtc_inverse_search #(
    parameter int WIDTH = 8,
    parameter int CLS_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CLS_W-1:0] req_class,
    output logic [WIDTH-1:0] cand,
    input  logic [CLS_W-1:0] cls,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_found,
    output logic [WIDTH-1:0] rsp_vec,
    output logic [WIDTH:0]   rsp_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CLS_W-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [WIDTH:0]   count_q, count_d;
    logic             found_q, found_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_found_q, rsp_found_d;
    logic [WIDTH-1:0] rsp_vec_q, rsp_vec_d;
    logic [WIDTH:0]   rsp_count_q, rsp_count_d;

    logic hit;
    logic last_cand;
    logic scan_done;

    assign hit       = (cls == tgt_q);
    assign last_cand = (cand_q == {WIDTH{1'b1}});

    // Early exit only changes when the sweep stops; the first hit always leaves count at 1.
`ifdef DTC_SEARCH_EARLY_EXIT_EN
    assign scan_done = last_cand || hit;
`else
    assign scan_done = last_cand;
`endif

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        cand_d      = cand_q;
        vec_d       = vec_q;
        count_d     = count_q;
        found_d     = found_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_found_d = rsp_found_q;
        rsp_vec_d   = rsp_vec_q;
        rsp_count_d = rsp_count_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    tgt_d       = req_class;
                    count_d     = '0;
                    found_d     = 1'b0;
                    vec_d       = '0;
                    cand_d      = '0;
                    req_ready_d = 1'b0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    count_d = count_q + (WIDTH+1)'(1);
                    if (!found_q) begin
                        found_d = 1'b1;
                        vec_d   = cand_q;
                    end
                end
                cand_d = cand_q + WIDTH'(1);
                // Results are published from the next-state values so the last sample counts.
                if (scan_done) begin
                    cand_d      = '0;
                    rsp_valid_d = 1'b1;
                    rsp_found_d = found_d;
                    rsp_vec_d   = vec_d;
                    rsp_count_d = count_d;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                cand_d      = '0;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tgt_q       <= '0;
            cand_q      <= '0;
            vec_q       <= '0;
            count_q     <= '0;
            found_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_found_q <= 1'b0;
            rsp_vec_q   <= '0;
            rsp_count_q <= '0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            cand_q      <= cand_d;
            vec_q       <= vec_d;
            count_q     <= count_d;
            found_q     <= found_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_found_q <= rsp_found_d;
            rsp_vec_q   <= rsp_vec_d;
            rsp_count_q <= rsp_count_d;
        end
    end

    assign req_ready = req_ready_q;
    assign cand      = cand_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_found = rsp_found_q;
    assign rsp_vec   = rsp_vec_q;
    assign rsp_count = rsp_count_q;

endmodule

// File: tb/tb_dtc_inverse_search.sv
// Scoreboard bench for dtc_inverse_search: stub classifiers in the bench, expected
// results from a direct sweep model, monitor compares on each rising rsp_valid.
module tb_dtc_inverse_search;
    localparam int WIDTH = 8;
    localparam int CLS_W = 2;
    localparam int N     = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [CLS_W-1:0] req_class = '0;
    logic [WIDTH-1:0] cand;
    logic [CLS_W-1:0] cls;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic             rsp_found;
    logic [WIDTH-1:0] rsp_vec;
    logic [WIDTH:0]   rsp_count;

    dtc_inverse_search #(.WIDTH(WIDTH), .CLS_W(CLS_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_class(req_class),
        .cand(cand), .cls(cls),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_found(rsp_found), .rsp_vec(rsp_vec), .rsp_count(rsp_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub classifiers: 0 = low two bits, 1 = constant 0, 2 = only 0xFF is class 1, 3 = random table
    int               mode = 0;
    logic [CLS_W-1:0] lut [N];

    function automatic logic [CLS_W-1:0] stub(int m, int v);
        case (m)
            0:       return CLS_W'(v & 3);
            2:       return (v == N - 1) ? CLS_W'(1) : CLS_W'(0);
            default: return '0;
        endcase
    endfunction

    assign cls = (mode == 3) ? lut[cand] : stub(mode, int'(cand));

    function automatic logic [CLS_W-1:0] ref_cls(int v);
        return (mode == 3) ? lut[v] : stub(mode, v);
    endfunction

    typedef struct {
        logic             found;
        logic [WIDTH-1:0] vec;
        logic [WIDTH:0]   count;
        int               lat;
        int               acc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    logic prev_v = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per rising rsp_valid
    always @(negedge clk) begin
        if (rsp_valid && !prev_v) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
            end else begin
                mon_e = sbq.pop_front();
                chk("rsp_found", 32'(rsp_found), 32'(mon_e.found));
                chk("rsp_vec", 32'(rsp_vec), 32'(mon_e.vec));
                chk("rsp_count", 32'(rsp_count), 32'(mon_e.count));
                chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
        prev_v = rsp_valid;
    end

    task automatic issue(int m, logic [CLS_W-1:0] c);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_issue", 32'(req_ready), 32'd1);
        mode      = m;
        req_valid = 1'b1;
        req_class = c;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_class = CLS_W'($urandom);
        e.found = 1'b0;
        e.vec   = '0;
        e.count = '0;
        e.lat   = N;
        e.acc   = cyc;
        for (int v = 0; v < N; v++) begin
            if (ref_cls(v) == c) begin
                if (!e.found) begin
                    e.found = 1'b1;
                    e.vec   = WIDTH'(v);
                end
                e.count = e.count + 1'b1;
`ifdef DTC_SEARCH_EARLY_EXIT_EN
                e.lat = v + 1;
                break;
`endif
            end
        end
        sbq.push_back(e);
    endtask

    task automatic finish_query(int hold, bit poke);
        int               n;
        logic             f0;
        logic [WIDTH-1:0] v0;
        logic [WIDTH:0]   c0;
        n = 0;
        while (!rsp_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", 32'(rsp_valid), 32'd1);
            return;
        end
        f0 = rsp_found;
        v0 = rsp_vec;
        c0 = rsp_count;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (poke && i == 3) begin
                req_valid = 1'b1;
                req_class = ~req_class;
            end
            if (poke && i == 6) req_valid = 1'b0;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_found", 32'(rsp_found), 32'(f0));
            chk("hold_vec", 32'(rsp_vec), 32'(v0));
            chk("hold_count", 32'(rsp_count), 32'(c0));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("post_ack_valid", 32'(rsp_valid), 32'd0);
        chk("post_ack_req_ready", 32'(req_ready), 32'd1);
        if (poke) begin
            repeat (3) @(negedge clk);
            chk("no_capture_req_ready", 32'(req_ready), 32'd1);
            chk("no_capture_cand", 32'(cand), 32'd0);
            chk("no_capture_valid", 32'(rsp_valid), 32'd0);
        end
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_cand"}, 32'(cand), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_found"}, 32'(rsp_found), 32'd0);
        chk({tag, "_rsp_vec"}, 32'(rsp_vec), 32'd0);
        chk({tag, "_rsp_count"}, 32'(rsp_count), 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) lut[i] = CLS_W'($urandom);
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        issue(0, 2'd2); finish_query(0, 1'b0);
        issue(1, 2'd3); finish_query(1, 1'b0);
        issue(1, 2'd0); finish_query(0, 1'b0);
        issue(2, 2'd1); finish_query(2, 1'b0);
        issue(3, CLS_W'($urandom)); finish_query(10, 1'b1);

        // Abort a scan at cand=100; outputs must drop to reset values at once
        issue(3, CLS_W'($urandom));
        void'(sbq.pop_back());
        n = 0;
        while (cand != WIDTH'(100) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_cand", 32'(cand), 32'd100);
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        rst_n = 1'b1;

        issue(0, 2'd3); finish_query(0, 1'b0);

        for (int q = 0; q < 6; q++) begin
            for (int i = 0; i < N; i++) lut[i] = CLS_W'($urandom);
            if (q == 2) for (int i = 0; i < N; i++) lut[i] = (lut[i] == 2'd1) ? 2'd0 : lut[i];
            issue(3, (q == 2) ? 2'd1 : CLS_W'($urandom));
            finish_query($urandom_range(0, 3), 1'b0);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dtc_inverse_search.md
# dtc_inverse_search

Sequential inverse-query engine for the 8-input / 2-bit-class decision-tree classifiers. It takes a requested class and sweeps every input vector through an externally instantiated, purely combinational classifier. It then reports the lowest input vector that produces that class and the number of vectors that do. It sits on the driving side of the classifier (it drives the classifier's input and consumes its class output) and is used for coverage and inverse-lookup of trained trees.

## Interface
- WIDTH, 8, classifier input width; the sweep covers 0 .. 2^WIDTH-1
- CLS_W, 2, classifier class width
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  query request valid
- req_ready  out  1  high only in IDLE
- req_class  in  CLS_W  target class; captured on the accept edge
- cand  out  WIDTH  candidate vector driven to the classifier input
- cls  in  CLS_W  classifier output for cand; combinational in the same cycle
- rsp_valid  out  1  result valid; held until accepted
- rsp_ready  in  1  result consumer ready
- rsp_found  out  1  at least one matching vector exists
- rsp_vec  out  WIDTH  lowest matching vector; 0 when rsp_found=0
- rsp_count  out  WIDTH+1  number of matching vectors (0 .. 2^WIDTH)

## Operation
- States: IDLE, SCAN, RESP.
- IDLE
  - req_ready=1 and cand=0.
  - When req_valid&&req_ready: capture req_class into tgt, clear count/found/vec, go to SCAN.
- SCAN (req_ready=0)
  - Each cycle, compare cls with tgt.
  - On a match: count += 1. If found=0, set vec=cand and found=1.
  - cand increments by 1 per cycle, starting at 0.
  - After the cycle evaluating cand=2^WIDTH-1: go to RESP. cand returns to 0; no wrap re-evaluation.
- RESP
  - rsp_valid=1; rsp_found/rsp_vec/rsp_count are stable.
  - When rsp_valid&&rsp_ready: go to IDLE.
  - A new request cannot be accepted in the same cycle, because req_ready=0 in RESP.
- req_valid is ignored outside IDLE, and req_class changes after accept are ignored.
- Count arithmetic is unsigned WIDTH+1 bits and cannot overflow (maximum 2^WIDTH).
- Reset, asynchronous at any point including mid-SCAN or RESP, aborts the query. All outputs return to reset values.

## Timing
- Reset values:
  - req_ready=1
  - cand=0
  - rsp_valid=0
  - rsp_found=0
  - rsp_vec=0
  - rsp_count=0
  - state=IDLE
- Accept edge A. Candidate k is presented in the cycle after edge A+k and sampled at edge A+k+1.
- rsp_valid rises after edge A+2^WIDTH (256 cycles of SCAN for WIDTH=8). Early-exit variant: see Configuration.
- rsp_* outputs are registered and change only on the SCAN->RESP edge or on reset.
- rsp_ready held low: rsp_valid and data hold indefinitely.
- rsp_ready already high when RESP is entered: IDLE follows one cycle later, so the minimum RESP dwell is 1 cycle.
- Request-to-request throughput: 2^WIDTH+2 cycles with full scan.

## Configuration
- DTC_SEARCH_EARLY_EXIT_EN
  - Defined: SCAN ends on the edge that samples the first match. rsp_count=1 when found and 0 otherwise; rsp_vec is the first match. Latency to rsp_valid is m+1 cycles after accept for a match at vector m, or the full 2^WIDTH with no match.
  - Undefined: always a full sweep, and rsp_count is the exact total.

## Test plan
- Stub classifier cls=cand[1:0], req_class=2 (full scan) -> rsp_found=1, rsp_vec=2, rsp_count=64, rsp_valid exactly 256 cycles after accept.
- Stub classifier cls=0 constant, req_class=3 -> rsp_found=0, rsp_vec=0, rsp_count=0. The same stub with req_class=0 gives rsp_count=256 and rsp_vec=0.
- Stub cls=(cand==8'hFF)?1:0, req_class=1 -> rsp_vec=8'hFF, rsp_count=1. This checks the last-candidate boundary with no wrap double count.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP, pulse req_valid -> outputs stable, req_ready=0, no new capture. Then rsp_ready=1 -> IDLE next cycle and req_ready=1.
- Assert rst_n=0 at cand=100 mid-SCAN -> all outputs go to reset values immediately. A subsequent query completes correctly.
- With DTC_SEARCH_EARLY_EXIT_EN, stub cls=cand[1:0], req_class=3 -> rsp_vec=3, rsp_count=1, rsp_valid 4 cycles after accept.
